ring_osc_meter: RTL

Round-robin frequency meter and scheduler for the on-chip ring oscillator bank (clk_03 … clk_19 taps). It walks an enable mask of oscillator outputs and, for each selected oscillator, counts rising edges over a programmable gate window of `clk` cycles. Each count is presented on a valid/ready result port for the logic analyzer or Wishbone side to collect. It sits in `user_project_wrapper` between the ring oscillator outputs and the LA/user_code readout.

---
 rtl/ring_osc_meter_if.sv | 21 ++
 rtl/ring_osc_meter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ring_osc_meter_if.sv
// Result port of the ring oscillator meter: one count per selected oscillator,
// offered with valid/ready.
interface ring_osc_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             res_valid;
  logic             res_ready;
  logic [2:0]       res_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  modport master (
    output res_valid, res_idx, res_count, res_ovf,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx, res_count, res_ovf,
    output res_ready
  );
endinterface

// File: rtl/ring_osc_meter.sv
// Round-robin ring oscillator frequency meter: walks the latched enable mask and
// counts synchronized rising edges of each selected oscillator over a gate window.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; config latched when start is seen
// S_SETTLE | 4 cycles flushing the synchronizer after a select change
// S_GATE   | counting rising edges for the latched gate length
// S_REPORT | result offered on res until the valid/ready handshake
module ring_osc_meter #(
  parameter int NUM_OSC = 7,
  parameter int GATE_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_OSC-1:0] osc_in,
  input  logic               start,
  input  logic               continuous,
  input  logic [GATE_W-1:0]  gate_len,
  input  logic [NUM_OSC-1:0] osc_mask,
  output logic               busy,
  output logic               done,
  ring_osc_meter_if.master   res
);

  localparam int SETTLE_LEN = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_REPORT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_OSC-1:0] sync1;
  logic [NUM_OSC-1:0] sync2;
  logic [NUM_OSC-1:0] dly;
  logic [NUM_OSC-1:0] mask_q;
  logic [GATE_W-1:0]  gate_q;
  logic [GATE_W-1:0]  tmr;
  logic [2:0]         sel;
  logic [2:0]         sel_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               latch_cfg;
  logic               done_nxt;
  logic [7:0]         rise_vec;
  logic               rise;
  logic [3:0]         first_in;
  logic [3:0]         first_q;
  logic [3:0]         next_up;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] find_set(input logic [NUM_OSC-1:0] m,
                                          input logic [3:0]         from);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign first_in = find_set(osc_mask, 4'd0);
  assign first_q  = find_set(mask_q, 4'd0);
  assign next_up  = find_set(mask_q, {1'b0, sel} + 4'd1);

  assign rise_vec = 8'(sync2 & ~dly);
  assign rise     = rise_vec[sel];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    latch_cfg = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          if (first_in[3]) begin
            state_nxt = S_SETTLE;
            sel_nxt   = first_in[2:0];
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (tmr == '0) state_nxt = S_GATE;
      end
      S_GATE: begin
        if (tmr == '0) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        if (res.res_ready) begin
          if (next_up[3]) begin
            state_nxt = S_SETTLE;
            sel_nxt   = next_up[2:0];
          end else begin
            done_nxt = 1'b1;
            if (continuous) begin
              state_nxt = S_SETTLE;
              sel_nxt   = first_q[2:0];
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      dly    <= '0;
      mask_q <= '0;
      gate_q <= '0;
      tmr    <= '0;
      sel    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      dly   <= sync2;
      sel   <= sel_nxt;
      done  <= done_nxt;
      if (latch_cfg) begin
        mask_q <= osc_mask;
        gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      end
      // Down-counter terminal count at zero ends both SETTLE and GATE.
      if (state != S_SETTLE && state_nxt == S_SETTLE)
        tmr <= GATE_W'(SETTLE_LEN - 1);
      else if (state == S_SETTLE && state_nxt == S_GATE)
        tmr <= gate_q - GATE_W'(1);
      else if (tmr != '0)
        tmr <= tmr - GATE_W'(1);
      if (state == S_SETTLE) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (state == S_GATE && rise) begin
        if (cnt == '1) ovf <= 1'b1;
        else           cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign busy          = (state != S_IDLE);
  assign res.res_valid = (state == S_REPORT);
  assign res.res_idx   = sel;
  assign res.res_count = cnt;
  assign res.res_ovf   = ovf;

endmodule
